fp_addsub_issue: RTL
====================

FP_ADDSUB_ISSUE -- requirements
Module: fp_addsub_issue

Interface
REQ-001 SHALL have parameter Size, default 64, operand/result width (32, 64 or 128).
REQ-002 SHALL have parameter Timeout, default 64, the maximum cycles to wait for fu_done.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset: synchronous and active-low.
REQ-005 SHALL have req_valid in 1, req_ready out 1, req_sub in 1, req_rm in 3, req_a in Size, req_b in Size: the request channel.
REQ-006 SHALL have frm in 3: the dynamic rounding mode, used when req_rm = 3'b111.
REQ-007 SHALL have resp_valid out 1, resp_ready in 1, resp_result out Size, resp_illegal out 1, resp_timeout out 1: the response channel.
REQ-008 SHALL have fu_start out 1, fu_sub out 1, fu_rm out 3, fu_a out Size, fu_b out Size: drive to add_sub_fp.
REQ-009 SHALL have fu_result in Size, fu_overflow, fu_underflow, fu_inexact, fu_invalid, fu_done in 1 each: returns from add_sub_fp.
REQ-010 SHALL have fflags out 5 {NV,DZ,OF,UF,NX} and fflags_clr in 1: the sticky accrued exceptions.

Function
REQ-011 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-012 SHALL, in IDLE, on req_valid&req_ready, latch sub, a, b and the effective rm (req_rm, or frm if req_rm = 111).
REQ-013 SHALL treat an effective rm of 101, 110 or 111 as illegal: go to RESP directly, resp_illegal = 1, resp_result = 0, fflags unchanged, fu_start not pulsed.
REQ-014 SHALL assert fu_start for exactly one cycle (ISSUE), then enter WAIT.
REQ-015 SHALL hold fu_sub/fu_rm/fu_a/fu_b stable from ISSUE until leaving WAIT.
REQ-016 SHALL ignore fu_done during IDLE and ISSUE; in WAIT the first fu_done = 1 captures fu_result and flags, then goes to RESP.
REQ-017 SHALL count WAIT cycles; on reaching Timeout without fu_done: go to RESP, resp_timeout = 1, resp_result = canonical NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0), and set fflags.NV.
REQ-018 SHALL hold resp_valid = 1 in RESP, with all resp_* stable, until resp_ready = 1; then return to IDLE the next cycle (no back-to-back accept in the same cycle).
REQ-019 SHALL OR the captured flags into fflags on the done capture: NV|=invalid, OF|=overflow, UF|=underflow, NX|=inexact; DZ stays 0.
REQ-020 SHALL make fflags_clr clear fflags; if it coincides with a flag-OR cycle, the new flags win (clear then OR).
REQ-021 SHALL leave fu_done asserted in the RESP cycle without effect (no double accrual).
REQ-022 SHALL give latency req accept -> resp_valid of 2 + N cycles, where N is the WAIT cycles until fu_done (minimum N = 1).

Reset
REQ-023 SHALL, when reset_n = 0 at a clk edge, go to IDLE from any state (mid-WAIT included) and drop the pending operation; a later stale fu_done is ignored.
REQ-024 SHALL reset outputs to: req_ready 1 after reset, resp_valid 0, fu_start 0, resp_result 0, resp_illegal 0, resp_timeout 0, fflags 0, fu_* operand outputs 0, timeout counter 0.

Structure
REQ-025 SHALL place the rounding-mode encodings (RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100, DYN 111), the fflags bit indices and the state encoding in the shared fp package.
REQ-026 SHALL be a single module with no sub-modules; add_sub_fp is instantiated beside it by the parent and not inside it.

Verification (bench with add_sub_fp instantiated, Size = 64)
REQ-027 SHALL check: add, rm 000, a = 0x3FF8000000000000, b = 0xBFF8000000000000 -> resp_result 0x0, fflags 0.
REQ-028 SHALL check: sub, same operands -> resp_result 0x4008000000000000, one fu_start pulse, resp held 3 cycles under resp_ready low.
REQ-029 SHALL check: add, a = 0x7FEFF00000000001, b = 0x7FE0000000000000 -> 0x7FF0000000000000, fflags OF and NX set and sticky through a following exact op; fflags_clr then gives 0.
REQ-030 SHALL check: req_rm = 111 with frm = 101 -> resp_illegal 1, no fu_start, fflags unchanged; frm = 010 -> op executes with fu_rm = 010.
REQ-031 SHALL check: stub FU never asserts done, Timeout = 8 -> resp after 8 WAIT cycles, resp_timeout 1, result 0x7FF8000000000000, NV set.
REQ-032 SHALL check: reset_n low during WAIT, then the stub asserts fu_done -> no response, state IDLE, req_ready 1, fflags 0.

Source files
------------

// File: rtl/fp_addsub_issue_pkg.sv
// Shared encodings for the FP add/sub issue controller: rounding modes,
// accrued-flag bit positions and controller state encoding.
package fp_addsub_issue_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100,
        RM_DYN = 3'b111
    } rm_e;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Exponent field width of the IEEE format matching an operand width.
    function automatic int exp_width(input int size);
        case (size)
            32:      return 8;
            128:     return 15;
            default: return 11;
        endcase
    endfunction

endpackage

// File: rtl/fp_addsub_issue_if.sv
// Request/response channel, FU drive/return and accrued flags of the issue controller.
interface fp_addsub_issue_if #(parameter int Size = 64);

    logic            req_valid;
    logic            req_ready;
    logic            req_sub;
    logic [2:0]      req_rm;
    logic [Size-1:0] req_a;
    logic [Size-1:0] req_b;
    logic [2:0]      frm;

    logic            resp_valid;
    logic            resp_ready;
    logic [Size-1:0] resp_result;
    logic            resp_illegal;
    logic            resp_timeout;

    logic            fu_start;
    logic            fu_sub;
    logic [2:0]      fu_rm;
    logic [Size-1:0] fu_a;
    logic [Size-1:0] fu_b;
    logic [Size-1:0] fu_result;
    logic            fu_overflow;
    logic            fu_underflow;
    logic            fu_inexact;
    logic            fu_invalid;
    logic            fu_done;

    logic [4:0]      fflags;
    logic            fflags_clr;

    modport slave (
        input  req_valid, req_sub, req_rm, req_a, req_b, frm, resp_ready,
               fu_result, fu_overflow, fu_underflow, fu_inexact, fu_invalid, fu_done,
               fflags_clr,
        output req_ready, resp_valid, resp_result, resp_illegal, resp_timeout,
               fu_start, fu_sub, fu_rm, fu_a, fu_b, fflags
    );

    modport master (
        output req_valid, req_sub, req_rm, req_a, req_b, frm, resp_ready,
               fu_result, fu_overflow, fu_underflow, fu_inexact, fu_invalid, fu_done,
               fflags_clr,
        input  req_ready, resp_valid, resp_result, resp_illegal, resp_timeout,
               fu_start, fu_sub, fu_rm, fu_a, fu_b, fflags
    );

endinterface

// File: rtl/fp_addsub_issue.sv
// Issues one FP add/sub to an external add_sub_fp unit, waits with a timeout,
// returns the response and accrues sticky exception flags.
//
// state    | meaning
// ST_IDLE  | req_ready high, waiting for a request
// ST_ISSUE | fu_start pulse, operands presented to the FU
// ST_WAIT  | operands held, waiting for fu_done or timeout
// ST_RESP  | resp_valid held until resp_ready
module fp_addsub_issue
    import fp_addsub_issue_pkg::*;
#(
    parameter int Size    = 64,
    parameter int Timeout = 64
) (
    input logic              clk,
    input logic              reset_n,
    fp_addsub_issue_if.slave bus
);

    localparam int EW = exp_width(Size);
    localparam int CW = $clog2(Timeout + 1);
    localparam logic [Size-1:0] CANON_NAN = {1'b0, {EW{1'b1}}, 1'b1, {(Size-EW-2){1'b0}}};
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(Timeout - 1);

    state_e          state_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic            resp_illegal_q;
    logic            resp_timeout_q;
    logic [Size-1:0] resp_result_q;
    logic            fu_start_q;
    logic            fu_sub_q;
    logic [2:0]      fu_rm_q;
    logic [Size-1:0] fu_a_q;
    logic [Size-1:0] fu_b_q;
    logic [CW-1:0]   cnt_q;
    logic [4:0]      fflags_q;
    logic [4:0]      fflags_d;
    logic [4:0]      accrue_d;
    logic [2:0]      eff_rm_d;
    logic            done_hit_d;
    logic            tmo_hit_d;

    always_comb begin
        eff_rm_d   = (bus.req_rm == RM_DYN) ? bus.frm : bus.req_rm;
        done_hit_d = (state_q == ST_WAIT) && bus.fu_done;
        tmo_hit_d  = (state_q == ST_WAIT) && !bus.fu_done && (cnt_q == '0);
        accrue_d   = '0;
        if (done_hit_d) begin
            accrue_d[FF_NV] = bus.fu_invalid;
            accrue_d[FF_OF] = bus.fu_overflow;
            accrue_d[FF_UF] = bus.fu_underflow;
            accrue_d[FF_NX] = bus.fu_inexact;
        end
        if (tmo_hit_d) begin
            accrue_d[FF_NV] = 1'b1;
        end
        // Clear applies first so flags raised in the same cycle survive it.
        fflags_d = (bus.fflags_clr ? 5'b0 : fflags_q) | accrue_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_illegal_q <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_result_q  <= '0;
            fu_start_q     <= 1'b0;
            fu_sub_q       <= 1'b0;
            fu_rm_q        <= 3'b000;
            fu_a_q         <= '0;
            fu_b_q         <= '0;
            cnt_q          <= '0;
            fflags_q       <= 5'b0;
        end else begin
            fflags_q <= fflags_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (eff_rm_d > RM_RMM) begin
                            state_q        <= ST_RESP;
                            resp_valid_q   <= 1'b1;
                            resp_illegal_q <= 1'b1;
                            resp_timeout_q <= 1'b0;
                            resp_result_q  <= '0;
                        end else begin
                            state_q    <= ST_ISSUE;
                            fu_start_q <= 1'b1;
                            fu_sub_q   <= bus.req_sub;
                            fu_rm_q    <= eff_rm_d;
                            fu_a_q     <= bus.req_a;
                            fu_b_q     <= bus.req_b;
                            cnt_q      <= CNT_LOAD;
                        end
                    end
                end
                ST_ISSUE: begin
                    fu_start_q <= 1'b0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_hit_d) begin
                        state_q        <= ST_RESP;
                        resp_valid_q   <= 1'b1;
                        resp_illegal_q <= 1'b0;
                        resp_timeout_q <= 1'b0;
                        resp_result_q  <= bus.fu_result;
                    end else if (tmo_hit_d) begin
                        state_q        <= ST_RESP;
                        resp_valid_q   <= 1'b1;
                        resp_illegal_q <= 1'b0;
                        resp_timeout_q <= 1'b1;
                        resp_result_q  <= CANON_NAN;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_result  = resp_result_q;
    assign bus.resp_illegal = resp_illegal_q;
    assign bus.resp_timeout = resp_timeout_q;
    assign bus.fu_start     = fu_start_q;
    assign bus.fu_sub       = fu_sub_q;
    assign bus.fu_rm        = fu_rm_q;
    assign bus.fu_a         = fu_a_q;
    assign bus.fu_b         = fu_b_q;
    assign bus.fflags       = fflags_q;

endmodule
